dsp_source_fifo: RTL and testbench
==================================

Name: dsp_source_fifo

Overview:
- Packet buffer directly downstream of the DSP stage.
- Accepts the DSP Avalon-ST source stream (32-bit words with sop/eop) and presents it to the stream-to-memory DMA write master.
- Absorbs DMA backpressure and exposes fill level and stored-packet count.
- Optional store-and-forward mode: the DMA never sees a partial packet unless the buffer is full.

Parameters:
DEPTH, 16, number of stored beats; power of two, minimum 4
STORE_FORWARD, 1, 1 = release data only when a complete packet (or a full buffer) is held; 0 = cut-through
LVL_W, $clog2(DEPTH)+1, width of fill_level and pkt_count (derived, not overridden)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
flush  in  1  synchronous clear of all stored beats
sink_ready  out  1  Avalon-ST ready toward DSP stage, ready latency 0
sink_data  in  32  beat data from DSP stage
sink_valid  in  1  beat valid
sink_sop  in  1  start of packet
sink_eop  in  1  end of packet
source_data  out  32  beat data toward DMA
source_valid  out  1  beat valid
source_sop  out  1  start of packet
source_eop  out  1  end of packet
source_ready  in  1  DMA ready, ready latency 0
fill_level  out  LVL_W  beats currently stored, 0..DEPTH
pkt_count  out  LVL_W  eop beats currently stored

Behaviour:
- Entry = {sop, eop, data}, 34 bits.
  - Stored and returned unmodified.
  - No byte swapping.
  - No sop/eop legality checking.
- Write fires when sink_valid && sink_ready.
- Read fires when source_valid && source_ready.
- Pointers wrap modulo DEPTH.
- sink_ready = (fill_level != DEPTH) && !flush, combinational from registered state.
  - When full, no write is accepted, even in a cycle where a read fires. No pass-through.
- Show-ahead output: source_* is driven from the entry at the read pointer.
  - A beat written in cycle N can appear on source in cycle N+1 at the earliest, when that mode's release condition is already met.
  - In store-and-forward mode, an eop beat written in cycle N releases the packet at N+1.
- source_valid:
  - !empty && !flush when STORE_FORWARD=0.
  - !empty && !flush && (pkt_count != 0 || fill_level == DEPTH) when STORE_FORWARD=1. The full-buffer escape prevents deadlock on packets longer than DEPTH.
- When source_valid=0, source_data/sop/eop are driven 0.
- Once source_valid is asserted, source_* holds stable until the read fires. The only exceptions are flush and reset.
- fill_level: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
- pkt_count:
  - +1 on a write with sink_eop.
  - -1 on a read of a beat with eop.
  - Unchanged when both occur in the same cycle.
  - Never exceeds fill_level.
- flush (one or more cycles):
  - Pointers, fill_level and pkt_count clear at the next edge.
  - During flush, sink_ready=0 and source_valid=0.
  - Beats present on sink during flush are not accepted.
  - Stored data is discarded; memory contents need not be cleared.
- Reset (rst_n=0 at a clock edge):
  - Same state clear as flush, from any state including mid-packet.
  - While rst_n is low: sink_ready=0, source_valid=0, source_data/sop/eop=0, fill_level=0, pkt_count=0.
  - sink_ready=1 in the first cycle after rst_n rises.
- rst_n and flush asserted together: reset result.
- Throughput: one beat per cycle in each direction simultaneously when neither full nor empty.

Decomposition:
- Shared package dsp_stream_pkg holds:
  - typedef dsp_st_beat_t (packed struct: sop, eop, data[31:0]).
  - constant DSP_ST_DATA_W = 32.
  - The DSP stage and DMA glue reuse these.
- Sub-module dsp_fifo_mem:
  - Simple dual-port array, DEPTH x dsp_st_beat_t.
  - Synchronous write, asynchronous read, so it maps to MLAB on Cyclone V.
- Pointer, count and valid logic stay in dsp_source_fifo.

Test Plan:
- Reset, then idle, DEPTH=16, STORE_FORWARD=0 → sink_ready=1 first cycle after reset. Write 3 beats 0xA0..0xA2 (sop on first, eop on last) with source_ready=1 → source shows 0xA0 one cycle after its write, beats emerge in order, fill_level returns to 0.
- STORE_FORWARD=1, source_ready=1 → write a 5-beat packet with one idle cycle between beats. source_valid stays 0 until the cycle after the eop write, then 5 consecutive beats; pkt_count goes 0→1→0.
- STORE_FORWARD=1, 20-beat packet, DEPTH=16, source_ready=1 → fill reaches 16, sink_ready=0, source_valid asserts via the full escape, and all 20 beats are delivered in order without deadlock.
- Fill to 16 with source_ready=0, then assert source_ready with sink_valid held high → sink_ready=0 in the full cycle and no write that cycle. Afterwards steady state at one beat in and one out per cycle; fill_level stays at 15/16.
- Simultaneous eop write and eop read with pkt_count=2 → pkt_count remains 2, fill_level unchanged.
- Mid-packet flush with fill_level=7, pkt_count=1, then rst_n=0 mid-packet on a second fill → after each event fill_level=0, pkt_count=0, source_valid=0. sink_ready=0 during flush/reset cycles and 1 after; no stale beat appears on source.

Source files
------------

// File: rtl/dsp_stream_pkg.sv
// -----------------------------------------------------------------------------
// dsp_stream_pkg
//   Shared Avalon-ST beat definitions for the DSP stage, its source FIFO and
//   the DMA glue.
//
//   DSP_ST_DATA_W    : payload width of one stream beat
//   dsp_st_beat_t    : {sop, eop, data}, stored and forwarded unmodified
//   DSP_ST_BEAT_W    : total packed width of a beat
//   dsp_st_make_beat : packs the three sink fields into one beat
// -----------------------------------------------------------------------------
package dsp_stream_pkg;

   localparam int unsigned DSP_ST_DATA_W = 32;

   typedef struct packed {
      logic                     sop;
      logic                     eop;
      logic [DSP_ST_DATA_W-1:0] data;
   } dsp_st_beat_t;

   localparam int unsigned DSP_ST_BEAT_W = $bits(dsp_st_beat_t);

   function automatic dsp_st_beat_t dsp_st_make_beat(
      input logic                     sop,
      input logic                     eop,
      input logic [DSP_ST_DATA_W-1:0] data
   );
      dsp_st_beat_t b;
      b.sop  = sop;
      b.eop  = eop;
      b.data = data;
      return b;
   endfunction

endpackage : dsp_stream_pkg

// File: rtl/dsp_fifo_mem.sv
// -----------------------------------------------------------------------------
// dsp_fifo_mem
//   Simple dual-port beat storage: one synchronous write port, one
//   asynchronous read port. The asynchronous read lets the parent FIFO present
//   the head entry in show-ahead fashion, and maps onto MLAB on Cyclone V.
//   No reset on the array: stale contents are never observed because the
//   parent only exposes entries between its read and write pointers.
//
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : beat to store
//   rd_addr : read address
//   rd_data : beat at rd_addr (combinational)
// -----------------------------------------------------------------------------
module dsp_fifo_mem
   import dsp_stream_pkg::*;
#(
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         wr_en,
   input  logic [AW-1:0] wr_addr,
   input  dsp_st_beat_t wr_data,
   input  logic [AW-1:0] rd_addr,
   output dsp_st_beat_t rd_data
);

   dsp_st_beat_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule : dsp_fifo_mem

// File: rtl/dsp_source_fifo.sv
// -----------------------------------------------------------------------------
// dsp_source_fifo
//   Packet buffer between the DSP stage Avalon-ST source and the
//   stream-to-memory DMA write master. Absorbs DMA backpressure, reports fill
//   level and number of complete packets held. With STORE_FORWARD=1 the DMA
//   only sees data once a whole packet is buffered, or once the buffer is full
//   (so packets longer than DEPTH cannot deadlock it).
//
//   clk, rst_n   : clock, synchronous active-low reset
//   flush        : synchronous discard of all stored beats
//   sink_*       : Avalon-ST input from DSP stage (ready latency 0)
//   source_*     : Avalon-ST output to DMA (ready latency 0, show-ahead)
//   fill_level   : beats stored, 0..DEPTH
//   pkt_count    : eop beats stored
// -----------------------------------------------------------------------------
module dsp_source_fifo
   import dsp_stream_pkg::*;
#(
   parameter  int unsigned DEPTH         = 16,
   parameter  int unsigned STORE_FORWARD = 1,
   localparam int unsigned LVL_W         = $clog2(DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,

   output logic                     sink_ready,
   input  logic [DSP_ST_DATA_W-1:0] sink_data,
   input  logic                     sink_valid,
   input  logic                     sink_sop,
   input  logic                     sink_eop,

   output logic [DSP_ST_DATA_W-1:0] source_data,
   output logic                     source_valid,
   output logic                     source_sop,
   output logic                     source_eop,
   input  logic                     source_ready,

   output logic [LVL_W-1:0]         fill_level,
   output logic [LVL_W-1:0]         pkt_count
);

   localparam int unsigned      AW       = $clog2(DEPTH);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LVL_W-1:0] fill_q;
   logic [LVL_W-1:0] pkt_q;

   dsp_st_beat_t wr_beat;
   dsp_st_beat_t rd_beat;

   logic full;
   logic empty;
   logic release_ok;
   logic live;
   logic sink_ready_i;
   logic source_valid_i;
   logic wr_fire;
   logic rd_fire;
   logic wr_eop;
   logic rd_eop;

   // --------------------------------------------------------------------------
   // Handshake and release decisions, all from registered state
   // --------------------------------------------------------------------------
   always_comb begin
      full  = (fill_q == LVL_FULL);
      empty = (fill_q == '0);
      live  = rst_n && !flush;

      // Store-and-forward: a complete packet is held, or the buffer is full
      // and must drain regardless to avoid deadlock on oversized packets.
      if (STORE_FORWARD != 0) begin
         release_ok = (pkt_q != '0) || full;
      end else begin
         release_ok = 1'b1;
      end

      // No pass-through when full: a read in the same cycle does not open a slot.
      sink_ready_i   = live && !full;
      source_valid_i = live && !empty && release_ok;

      wr_fire = sink_valid && sink_ready_i;
      rd_fire = source_valid_i && source_ready;
      wr_eop  = wr_fire && sink_eop;
      rd_eop  = rd_fire && rd_beat.eop;
   end

   assign wr_beat = dsp_st_make_beat(sink_sop, sink_eop, sink_data);

   // --------------------------------------------------------------------------
   // Storage
   // --------------------------------------------------------------------------
   dsp_fifo_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_fire),
      .wr_addr (wr_ptr),
      .wr_data (wr_beat),
      .rd_addr (rd_ptr),
      .rd_data (rd_beat)
   );

   // --------------------------------------------------------------------------
   // Pointers and counters; DEPTH is a power of two so pointers wrap naturally
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill_q <= '0;
         pkt_q  <= '0;
      end else begin
         if (wr_fire) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_fire) begin
            rd_ptr <= rd_ptr + AW'(1);
         end

         case ({wr_fire, rd_fire})
            2'b10:   fill_q <= fill_q + LVL_W'(1);
            2'b01:   fill_q <= fill_q - LVL_W'(1);
            default: fill_q <= fill_q;
         endcase

         case ({wr_eop, rd_eop})
            2'b10:   pkt_q <= pkt_q + LVL_W'(1);
            2'b01:   pkt_q <= pkt_q - LVL_W'(1);
            default: pkt_q <= pkt_q;
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Outputs: payload zeroed while not valid; status forced to zero in reset
   // --------------------------------------------------------------------------
   always_comb begin
      sink_ready   = sink_ready_i;
      source_valid = source_valid_i;
      source_data  = source_valid_i ? rd_beat.data : '0;
      source_sop   = source_valid_i ? rd_beat.sop  : 1'b0;
      source_eop   = source_valid_i ? rd_beat.eop  : 1'b0;
      fill_level   = rst_n ? fill_q : '0;
      pkt_count    = rst_n ? pkt_q  : '0;
   end

endmodule : dsp_source_fifo

// File: tb/tb_dsp_source_fifo.sv
// -----------------------------------------------------------------------------
// tb_dsp_source_fifo
//   Drives one cut-through (STORE_FORWARD=0) and one store-and-forward
//   (STORE_FORWARD=1) instance from the same stimulus. Each instance has a
//   queue-based reference model; every cycle the outputs are compared against
//   it, and directed points carry hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_dsp_source_fifo;

   localparam int DEPTH = 16;
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        flush;
   logic        sink_valid;
   logic        sink_sop;
   logic        sink_eop;
   logic [31:0] sink_data;
   logic        source_ready;

   int checks   = 0;
   int failures = 0;

   // g = STORE_FORWARD setting of the instance
   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic             s_ready, s_valid, s_sop, s_eop;
      logic [31:0]      s_data;
      logic [LVL_W-1:0] fill, pkts;

      dsp_source_fifo #(
         .DEPTH         (DEPTH),
         .STORE_FORWARD (g)
      ) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .flush        (flush),
         .sink_ready   (s_ready),
         .sink_data    (sink_data),
         .sink_valid   (sink_valid),
         .sink_sop     (sink_sop),
         .sink_eop     (sink_eop),
         .source_data  (s_data),
         .source_valid (s_valid),
         .source_sop   (s_sop),
         .source_eop   (s_eop),
         .source_ready (source_ready),
         .fill_level   (fill),
         .pkt_count    (pkts)
      );

      // Reference model: queue of {sop, eop, data}
      logic [33:0] q[$];
      int          m_size = 0;
      int          m_pkts = 0;
      logic [33:0] m_head = '0;

      always @(posedge clk) begin
         bit can_send;
         bit do_rd;
         bit do_wr;
         can_send = (q.size() > 0) && (g == 0 || m_pkts > 0 || q.size() == DEPTH);
         do_rd    = can_send && source_ready;
         do_wr    = sink_valid && (q.size() < DEPTH);
         if (!rst_n || flush) begin
            q.delete();
            m_pkts = 0;
         end else begin
            if (do_rd) begin
               if (q[0][32]) m_pkts--;
               void'(q.pop_front());
            end
            if (do_wr) begin
               q.push_back({sink_sop, sink_eop, sink_data});
               if (sink_eop) m_pkts++;
            end
         end
         m_size = q.size();
         m_head = (m_size > 0) ? q[0] : '0;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_dut(input int id, input logic rdy, input logic vld,
                              input logic sop, input logic eop, input logic [31:0] data,
                              input logic [LVL_W-1:0] fill, input logic [LVL_W-1:0] pkts,
                              input int esize, input int epkts, input logic [33:0] head);
      logic live;
      logic e_vld;
      live  = rst_n && !flush;
      e_vld = live && (esize > 0) && (id == 0 || epkts > 0 || esize == DEPTH);
      check($sformatf("dut%0d_sink_ready", id), rdy, live && (esize < DEPTH));
      check($sformatf("dut%0d_source_valid", id), vld, e_vld);
      check($sformatf("dut%0d_source_sop", id), sop, e_vld ? head[33] : 1'b0);
      check($sformatf("dut%0d_source_eop", id), eop, e_vld ? head[32] : 1'b0);
      check($sformatf("dut%0d_source_data", id), data, e_vld ? head[31:0] : 32'h0);
      check($sformatf("dut%0d_fill_level", id), fill, rst_n ? esize : 0);
      check($sformatf("dut%0d_pkt_count", id), pkts, rst_n ? epkts : 0);
   endtask

   always @(negedge clk) begin
      compare_dut(0, g_dut[0].s_ready, g_dut[0].s_valid, g_dut[0].s_sop, g_dut[0].s_eop,
                  g_dut[0].s_data, g_dut[0].fill, g_dut[0].pkts,
                  g_dut[0].m_size, g_dut[0].m_pkts, g_dut[0].m_head);
      compare_dut(1, g_dut[1].s_ready, g_dut[1].s_valid, g_dut[1].s_sop, g_dut[1].s_eop,
                  g_dut[1].s_data, g_dut[1].fill, g_dut[1].pkts,
                  g_dut[1].m_size, g_dut[1].m_pkts, g_dut[1].m_head);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic s, input logic e);
      sink_valid = v;
      sink_data  = d;
      sink_sop   = s;
      sink_eop   = e;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      int rx;
      int maxf;
      bit esc;

      rst_n = 1'b0;
      flush = 1'b0;
      source_ready = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      repeat (3) cyc();
      rst_n = 1'b1;
      source_ready = 1'b1;

      // ---- cut-through: 3-beat packet A0..A2 ----
      drive(1'b1, 32'hA0, 1'b1, 1'b0); #2;
      check("t1_ready_after_reset", g_dut[0].s_ready, 1'b1);
      check("t1_valid_before_write", g_dut[0].s_valid, 1'b0);
      cyc(); drive(1'b1, 32'hA1, 1'b0, 1'b0); #2;
      check("t1_a0_next_cycle", g_dut[0].s_data, 32'hA0);
      check("t1_a0_sop", g_dut[0].s_sop, 1'b1);
      check("t1_fill_one", g_dut[0].fill, 5'd1);
      cyc(); drive(1'b1, 32'hA2, 1'b0, 1'b1); #2;
      check("t1_a1", g_dut[0].s_data, 32'hA1);
      cyc(); drive(1'b0, 32'h0, 1'b0, 1'b0); #2;
      check("t1_a2", g_dut[0].s_data, 32'hA2);
      check("t1_a2_eop", g_dut[0].s_eop, 1'b1);
      check("t1_sf_release_a0", g_dut[1].s_data, 32'hA0);
      check("t1_sf_pkt_one", g_dut[1].pkts, 5'd1);
      check("t1_sf_fill_three", g_dut[1].fill, 5'd3);
      cyc(); #2;
      check("t1_fill_back_zero", g_dut[0].fill, 5'd0);
      repeat (4) cyc();

      // ---- store-and-forward: 5-beat packet with idle gaps ----
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'hB0 + i, i == 0, i == 4); #2;
         check("t2_hold_on_beat", g_dut[1].s_valid, 1'b0);
         cyc(); drive(1'b0, 32'h0, 1'b0, 1'b0); #2;
         if (i < 4) begin
            check("t2_hold_on_idle", g_dut[1].s_valid, 1'b0);
         end else begin
            check("t2_release_valid", g_dut[1].s_valid, 1'b1);
            check("t2_release_b0", g_dut[1].s_data, 32'hB0);
            check("t2_pkt_one", g_dut[1].pkts, 5'd1);
            check("t2_fill_five", g_dut[1].fill, 5'd5);
         end
         cyc();
      end
      for (int j = 1; j < 5; j++) begin
         #2;
         check("t2_burst_valid", g_dut[1].s_valid, 1'b1);
         check("t2_burst_data", g_dut[1].s_data, 32'hB0 + j);
         check("t2_burst_pkt", g_dut[1].pkts, 5'd1);
         cyc();
      end
      #2;
      check("t2_drained_pkt", g_dut[1].pkts, 5'd0);
      check("t2_drained_valid", g_dut[1].s_valid, 1'b0);
      repeat (2) cyc();

      // ---- store-and-forward: 20-beat packet longer than DEPTH ----
      idx = 0; rx = 0; maxf = 0; esc = 1'b0;
      for (int c = 0; c < 200 && rx < 20; c++) begin
         if (idx < 20) drive(1'b1, 32'hC0 + idx, idx == 0, idx == 19);
         else          drive(1'b0, 32'h0, 1'b0, 1'b0);
         #2;
         if (int'(g_dut[1].fill) > maxf) maxf = int'(g_dut[1].fill);
         if (g_dut[1].fill == 5'd16 && g_dut[1].s_valid && !g_dut[1].s_ready) esc = 1'b1;
         if (g_dut[1].s_valid) begin
            check("t3_order", g_dut[1].s_data, 32'hC0 + rx);
            rx++;
         end
         if (idx < 20 && g_dut[1].s_ready) idx++;
         cyc();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      check("t3_delivered", rx, 20);
      check("t3_max_fill", maxf, 16);
      check("t3_full_escape", esc, 1'b1);
      repeat (4) cyc();

      // ---- fill to DEPTH with backpressure, then steady state ----
      source_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 40 && idx < 16; c++) begin
         drive(1'b1, 32'hD0 + idx, 1'b0, 1'b0); #2;
         if (g_dut[0].s_ready) idx++;
         cyc();
      end
      drive(1'b1, 32'hD0 + idx, 1'b0, 1'b0);
      source_ready = 1'b1; #2;
      check("t4_full_ready_low", g_dut[0].s_ready, 1'b0);
      check("t4_full_fill", g_dut[0].fill, 5'd16);
      check("t4_full_head", g_dut[0].s_data, 32'hD0);
      cyc();
      for (int k = 0; k < 4; k++) begin
         #2;
         check("t4_steady_fill", g_dut[0].fill, 5'd15);
         check("t4_steady_ready", g_dut[0].s_ready, 1'b1);
         check("t4_steady_head", g_dut[0].s_data, 32'hD1 + k);
         if (g_dut[0].s_ready) idx++;
         cyc();
         drive(1'b1, 32'hD0 + idx, 1'b0, 1'b0);
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      source_ready = 1'b0;
      flush = 1'b1;
      cyc();
      flush = 1'b0; #2;
      check("t4_flushed_fill", g_dut[1].fill, 5'd0);

      // ---- simultaneous eop write and eop read at pkt_count=2 ----
      cyc();
      drive(1'b1, 32'hE0, 1'b1, 1'b1); cyc();
      drive(1'b1, 32'hE1, 1'b1, 1'b1); cyc();
      drive(1'b1, 32'hE2, 1'b1, 1'b1);
      source_ready = 1'b1; #2;
      check("t5_pkt_before", g_dut[1].pkts, 5'd2);
      check("t5_head_e0", g_dut[1].s_data, 32'hE0);
      cyc();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      source_ready = 1'b0; #2;
      check("t5_pkt_after", g_dut[1].pkts, 5'd2);
      check("t5_fill_after", g_dut[1].fill, 5'd2);
      check("t5_head_e1", g_dut[1].s_data, 32'hE1);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      cyc();

      // ---- mid-packet flush at fill 7 / one packet ----
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 32'hF0 + i, i == 0, i == 2);
         cyc();
      end
      drive(1'b1, 32'hFF, 1'b1, 1'b0);
      flush = 1'b1; #2;
      check("t6_flush_ready", g_dut[1].s_ready, 1'b0);
      check("t6_flush_valid", g_dut[0].s_valid, 1'b0);
      check("t6_pre_fill", g_dut[1].fill, 5'd7);
      check("t6_pre_pkt", g_dut[1].pkts, 5'd1);
      cyc();
      flush = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0); #2;
      check("t6_post_fill", g_dut[0].fill, 5'd0);
      check("t6_post_pkt", g_dut[1].pkts, 5'd0);
      check("t6_post_ready", g_dut[1].s_ready, 1'b1);
      source_ready = 1'b1;
      repeat (2) cyc();

      // ---- reset mid-packet on a second fill ----
      source_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h9A0 + i, i == 0, 1'b0);
         cyc();
      end
      rst_n = 1'b0; #2;
      check("t7_rst_ready", g_dut[0].s_ready, 1'b0);
      check("t7_rst_valid", g_dut[0].s_valid, 1'b0);
      check("t7_rst_fill", g_dut[0].fill, 5'd0);
      check("t7_rst_data", g_dut[0].s_data, 32'h0);
      repeat (2) cyc();
      rst_n = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0); #2;
      check("t7_after_ready", g_dut[1].s_ready, 1'b1);
      check("t7_after_fill", g_dut[1].fill, 5'd0);
      source_ready = 1'b1;
      repeat (3) cyc();

      // ---- reset and flush together ----
      drive(1'b1, 32'h5A5, 1'b1, 1'b1); cyc();
      drive(1'b1, 32'h5A6, 1'b1, 1'b1);
      rst_n = 1'b0; flush = 1'b1;
      cyc();
      rst_n = 1'b1; flush = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0); #2;
      check("t8_fill_zero", g_dut[1].fill, 5'd0);
      check("t8_ready", g_dut[1].s_ready, 1'b1);
      repeat (3) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_dsp_source_fifo
